reg_wb_writer: RTL and testbench
================================

Name: reg_wb_writer

Overview:
- MEM/WB writeback stage of the MIPS_2 pipeline; the producing end of the register-file write port.
- Accepts one retiring instruction per cycle from the EX/MEM side and, for loads, waits for the data memory.
- Extracts and extends load bytes/halfwords, selects ALU result or load data.
- Drives MW_RegWrite/MW_WBAddr/MW_WBData into the register file, and stalls upstream while a load is outstanding.

Parameters:
- WAIT_LIMIT, 15: maximum cycles spent in WAIT_MEM before the load is abandoned (1..255).
- PROTECT_R0, 1: when 1, writes to register 0 are suppressed; the register file does not protect r0 itself.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- EM_Valid  in  1  EX/MEM slot holds a valid instruction
- EM_RegWrite  in  1  instruction writes a GPR
- EM_MemToReg  in  1  instruction is a load
- EM_LoadType  in  3  0=LW 1=LB 2=LBU 3=LH 4=LHU; 5-7 reserved
- EM_WBAddr  in  5  destination register
- EM_ALUOut  in  32  ALU result, or the effective address for loads
- EM_Flush  in  1  kill the accepted/pending instruction
- DMEM_RData  in  32  data memory read word
- DMEM_Ack  in  1  DMEM_RData valid this cycle
- WB_Stall  out  1  upstream must hold EX/MEM
- MW_RegWrite  out  1  register-file write enable
- MW_WBAddr  out  5  register-file write address
- MW_WBData  out  32  register-file write data
- LOAD_Err  out  1  one-cycle pulse: load abandoned by timeout

Behaviour:
- Reset (async, rst_n low): state=IDLE, wait counter=0; MW_RegWrite=0, MW_WBAddr=0, MW_WBData=0, LOAD_Err=0.
- Reset mid-WAIT_MEM drops the pending load with no write.
- WB_Stall is combinational: high when state=WAIT_MEM and DMEM_Ack=0; also high in IDLE when a valid load is presented with DMEM_Ack=0.
- IDLE, EM_Valid=1, non-load: on the next edge MW_RegWrite=EM_RegWrite, MW_WBAddr=EM_WBAddr, MW_WBData=EM_ALUOut. Latency is 1 cycle.
- IDLE, EM_Valid=1, load, DMEM_Ack=1 in the same cycle: write the extracted data on the next edge (1-cycle latency).
- IDLE, EM_Valid=1, load, DMEM_Ack=0: capture WBAddr, LoadType and ALUOut[1:0]; go to WAIT_MEM; counter=1.
- WAIT_MEM, DMEM_Ack=1: write the extracted data on the next edge and return to IDLE.
- WAIT_MEM, DMEM_Ack=0:
  - counter increments.
  - When counter reaches WAIT_LIMIT with no ack: return to IDLE, no write, LOAD_Err pulses for 1 cycle.
- EM_Valid=0 or EM_Flush=1 in IDLE: MW_RegWrite=0 next cycle.
- EM_Flush=1 in WAIT_MEM: abandon to IDLE, no write, no LOAD_Err. Flush takes priority over a simultaneous DMEM_Ack.
- MW_RegWrite is a single-cycle pulse per retired instruction. When it is 0, MW_WBAddr/MW_WBData hold their last values.
- PROTECT_R0=1 and destination address 0: MW_RegWrite forced to 0; address and data still update.
- Load extraction (little-endian lanes, off = captured ALUOut[1:0]):
  - LW: whole word; off ignored.
  - LB / LBU: byte off, i.e. RData[8*off+7 : 8*off], sign- / zero-extended.
  - LH / LHU: halfword off[1], i.e. RData[16*off[1]+15 : 16*off[1]], sign- / zero-extended; off[0] ignored.
  - Reserved types behave as LW.
- Load with EM_RegWrite=0: memory handshake still completes; no register write.
- Only one load is outstanding at a time; upstream holds its inputs stable while WB_Stall=1.

Decomposition:
- Shared package (mips_defs): LoadType encodings (LT_LW..LT_LHU), state encodings (ST_IDLE, ST_WAIT_MEM), data width 32.
- One sub-module: load_extract, combinational (RData, off, LoadType -> 32-bit extended value), reusable by a future store-forwarding path.
- FSM, counter and output registers stay in the top.

Test Plan:
- ALU op: EM_Valid=1, RegWrite=1, WBAddr=5, ALUOut=0x1234_5678 -> next cycle MW_RegWrite=1, MW_WBAddr=5, MW_WBData=0x1234_5678; following cycle MW_RegWrite=0.
- LB with immediate ack: RData=0x80FF_7F01, off=3, LoadType=LB, WBAddr=9 -> MW_WBData=0xFFFF_FF80. Same with LBU -> 0x0000_0080. LH off=2 -> 0xFFFF_80FF.
- Delayed ack: load to r7, DMEM_Ack arrives 3 cycles later -> WB_Stall high 3 cycles; single MW_RegWrite pulse one cycle after ack with the extracted data.
- Timeout: WAIT_LIMIT=4, load issued, no ack -> WB_Stall high for the wait, no write, LOAD_Err pulses once, FSM back in IDLE and accepts a following ALU op normally.
- r0 guard: ALU op, WBAddr=0, ALUOut=0xDEAD_BEEF -> MW_RegWrite stays 0. Flush during WAIT_MEM asserted together with ack -> no write, no LOAD_Err.
- Async reset asserted mid-WAIT_MEM -> all outputs 0 immediately; after release, no residual write and WB_Stall=0.

Source files
------------

// File: rtl/reg_wb_writer_pkg.sv
// Shared MIPS_2 definitions: data width, load-type and writeback FSM encodings.
package mips_defs;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4
  } load_type_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  // Everything needed to finish a load once the memory answers.
  typedef struct packed {
    logic       rw;
    logic [4:0] addr;
    logic [2:0] lt;
    logic [1:0] off;
  } pend_ld_t;

endpackage

// File: rtl/reg_wb_writer_load_extract.sv
// Load lane extraction: picks byte/halfword out of a little-endian word and
// sign- or zero-extends it. Purely combinational so it can be shared later.
module load_extract
  import mips_defs::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then extension by load type; reserved codes fall back to LW.
  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    value    = rdata;
    case (load_type)
      LT_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  value = {24'd0, byte_sel};
      LT_LH:   value = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  value = {16'd0, half_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/reg_wb_writer.sv
// MEM/WB writeback stage: retires one instruction per cycle, waits on data
// memory for loads (with a timeout), and drives the register-file write port.
module reg_wb_writer
  import mips_defs::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter bit PROTECT_R0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EM_Valid,
  input  logic        EM_RegWrite,
  input  logic        EM_MemToReg,
  input  logic [2:0]  EM_LoadType,
  input  logic [4:0]  EM_WBAddr,
  input  logic [31:0] EM_ALUOut,
  input  logic        EM_Flush,
  input  logic [31:0] DMEM_RData,
  input  logic        DMEM_Ack,
  output logic        WB_Stall,
  output logic        MW_RegWrite,
  output logic [4:0]  MW_WBAddr,
  output logic [31:0] MW_WBData,
  output logic        LOAD_Err
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  wb_state_e   state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  pend_ld_t    pend;
  logic        cap;
  logic        retire;
  logic        ret_rw;
  logic [4:0]  ret_addr;
  logic [31:0] ret_data;
  logic        err_nxt;
  logic        wr_en;
  logic [1:0]  ext_off;
  logic [2:0]  ext_lt;
  logic [31:0] ext_val;

  // In IDLE the load being presented is extracted directly; while waiting,
  // the captured offset/type are used since upstream fields may be stale.
  always_comb begin
    ext_off = (state == ST_IDLE) ? EM_ALUOut[1:0] : pend.off;
    ext_lt  = (state == ST_IDLE) ? EM_LoadType    : pend.lt;
  end

  load_extract u_ext (
    .rdata     (DMEM_RData),
    .off       (ext_off),
    .load_type (ext_lt),
    .value     (ext_val)
  );

  // Next-state, wait counter, stall and retirement decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    retire    = 1'b0;
    ret_rw    = 1'b0;
    ret_addr  = EM_WBAddr;
    ret_data  = EM_ALUOut;
    err_nxt   = 1'b0;
    WB_Stall  = 1'b0;
    case (state)
      ST_IDLE: begin
        WB_Stall = EM_Valid && EM_MemToReg && !DMEM_Ack;
        if (EM_Valid && !EM_Flush) begin
          if (!EM_MemToReg) begin
            retire = 1'b1;
            ret_rw = EM_RegWrite;
          end else if (DMEM_Ack) begin
            retire   = 1'b1;
            ret_rw   = EM_RegWrite;
            ret_data = ext_val;
          end else begin
            cap       = 1'b1;
            state_nxt = ST_WAIT_MEM;
            cnt_nxt   = 8'd1;
          end
        end
      end
      ST_WAIT_MEM: begin
        WB_Stall = !DMEM_Ack;
        // Flush wins over a same-cycle ack: the load is dead either way.
        if (EM_Flush) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 8'd0;
        end else if (DMEM_Ack) begin
          retire    = 1'b1;
          ret_rw    = pend.rw;
          ret_addr  = pend.addr;
          ret_data  = ext_val;
          state_nxt = ST_IDLE;
          cnt_nxt   = 8'd0;
        end else if (cnt == LIMIT) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = 8'd0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
    endcase
  end

  // r0 is hardwired zero in the ISA but the register file does not enforce it.
  assign wr_en = retire && ret_rw && !(PROTECT_R0 && (ret_addr == 5'd0));

  // State, counter and captured load fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (cap) begin
        pend.rw   <= EM_RegWrite;
        pend.addr <= EM_WBAddr;
        pend.lt   <= EM_LoadType;
        pend.off  <= EM_ALUOut[1:0];
      end
    end
  end

  // Register-file write port; address/data hold between retirements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MW_RegWrite <= 1'b0;
      MW_WBAddr   <= 5'd0;
      MW_WBData   <= 32'd0;
      LOAD_Err    <= 1'b0;
    end else begin
      MW_RegWrite <= wr_en;
      LOAD_Err    <= err_nxt;
      if (retire) begin
        MW_WBAddr <= ret_addr;
        MW_WBData <= ret_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_writer.sv
// Bench for reg_wb_writer: directed test-plan steps followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_reg_wb_writer;

  localparam int LIM = 4;

  logic        clk, rst_n;
  logic        EM_Valid, EM_RegWrite, EM_MemToReg, EM_Flush, DMEM_Ack;
  logic [2:0]  EM_LoadType;
  logic [4:0]  EM_WBAddr;
  logic [31:0] EM_ALUOut, DMEM_RData;
  logic        WB_Stall, MW_RegWrite, LOAD_Err;
  logic [4:0]  MW_WBAddr;
  logic [31:0] MW_WBData;

  reg_wb_writer #(.WAIT_LIMIT(LIM), .PROTECT_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .EM_Valid(EM_Valid), .EM_RegWrite(EM_RegWrite), .EM_MemToReg(EM_MemToReg),
    .EM_LoadType(EM_LoadType), .EM_WBAddr(EM_WBAddr), .EM_ALUOut(EM_ALUOut),
    .EM_Flush(EM_Flush), .DMEM_RData(DMEM_RData), .DMEM_Ack(DMEM_Ack),
    .WB_Stall(WB_Stall), .MW_RegWrite(MW_RegWrite), .MW_WBAddr(MW_WBAddr),
    .MW_WBData(MW_WBData), .LOAD_Err(LOAD_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: at most one outstanding load, its age in wait cycles,
  // and the last values seen on the write port.
  bit          m_pend;
  int          m_age;
  logic [4:0]  m_addr;
  logic [2:0]  m_lt;
  logic [1:0]  m_off;
  logic        m_rw;
  logic        m_wr, m_err, m_stall;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  int stall_cnt, err_cnt, wr_cnt;

  function automatic logic [31:0] ref_ext(logic [31:0] w, logic [1:0] off, logic [2:0] lt);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (lt)
      3'd1:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_age = 0; m_wr = 0; m_err = 0; m_waddr = '0; m_wdata = '0;
  endtask

  // One clock: check combinational stall, advance the model, then check the
  // registered outputs just after the edge.
  task automatic tick(input string tag);
    logic n_wr, n_err;
    #2;
    m_stall = m_pend ? !DMEM_Ack : (EM_Valid && EM_MemToReg && !DMEM_Ack);
    chk({tag, ".stall"}, 32'(WB_Stall), 32'(m_stall));
    if (WB_Stall) stall_cnt++;
    n_wr = 0; n_err = 0;
    if (m_pend) begin
      if (EM_Flush) m_pend = 0;
      else if (DMEM_Ack) begin
        n_wr = m_rw && (m_addr != 0);
        m_waddr = m_addr;
        m_wdata = ref_ext(DMEM_RData, m_off, m_lt);
        m_pend = 0;
      end else if (m_age == LIM) begin
        m_pend = 0; n_err = 1;
      end else m_age++;
    end else if (EM_Valid && !EM_Flush) begin
      if (!EM_MemToReg || DMEM_Ack) begin
        n_wr = EM_RegWrite && (EM_WBAddr != 0);
        m_waddr = EM_WBAddr;
        m_wdata = EM_MemToReg ? ref_ext(DMEM_RData, EM_ALUOut[1:0], EM_LoadType) : EM_ALUOut;
      end else begin
        m_pend = 1; m_age = 1;
        m_addr = EM_WBAddr; m_lt = EM_LoadType; m_off = EM_ALUOut[1:0]; m_rw = EM_RegWrite;
      end
    end
    m_wr = n_wr; m_err = n_err;
    @(posedge clk);
    #1;
    chk({tag, ".wr"},   32'(MW_RegWrite), 32'(m_wr));
    chk({tag, ".err"},  32'(LOAD_Err),    32'(m_err));
    chk({tag, ".addr"}, 32'(MW_WBAddr),   32'(m_waddr));
    chk({tag, ".data"}, MW_WBData,        m_wdata);
    if (MW_RegWrite) wr_cnt++;
    if (LOAD_Err) err_cnt++;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [4:0] a, input logic [31:0] alu, input logic fl,
                       input logic [31:0] rd, input logic ack);
    EM_Valid = v; EM_RegWrite = rw; EM_MemToReg = m2r; EM_LoadType = lt;
    EM_WBAddr = a; EM_ALUOut = alu; EM_Flush = fl; DMEM_RData = rd; DMEM_Ack = ack;
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 0);
  endtask

  initial begin
    bit prev_stall;
    rst_n = 0;
    idle();
    model_reset();
    #3;
    chk("rst.wr",    32'(MW_RegWrite), 32'd0);
    chk("rst.addr",  32'(MW_WBAddr),   32'd0);
    chk("rst.data",  MW_WBData,        32'd0);
    chk("rst.err",   32'(LOAD_Err),    32'd0);
    chk("rst.stall", 32'(WB_Stall),    32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // ALU op
    drive(1, 1, 0, 3'd0, 5'd5, 32'h1234_5678, 0, 32'd0, 0);
    tick("alu");
    chk("alu.wr_k",   32'(MW_RegWrite), 32'd1);
    chk("alu.addr_k", 32'(MW_WBAddr),   32'd5);
    chk("alu.data_k", MW_WBData,        32'h1234_5678);
    idle(); tick("alu_after");
    chk("alu.pulse_k", 32'(MW_RegWrite), 32'd0);

    // Immediate-ack loads with lane extraction
    drive(1, 1, 1, 3'd1, 5'd9, 32'h0000_1003, 0, 32'h80FF_7F01, 1);
    tick("lb");  chk("lb.data_k", MW_WBData, 32'hFFFF_FF80);
    drive(1, 1, 1, 3'd2, 5'd9, 32'h0000_1003, 0, 32'h80FF_7F01, 1);
    tick("lbu"); chk("lbu.data_k", MW_WBData, 32'h0000_0080);
    drive(1, 1, 1, 3'd3, 5'd9, 32'h0000_1002, 0, 32'h80FF_7F01, 1);
    tick("lh");  chk("lh.data_k", MW_WBData, 32'hFFFF_80FF);
    drive(1, 1, 1, 3'd6, 5'd9, 32'h0000_1001, 0, 32'h80FF_7F01, 1);
    tick("rsv"); chk("rsv.data_k", MW_WBData, 32'h80FF_7F01);
    idle(); tick("gap");

    // Delayed ack: three stalled cycles, then one write
    stall_cnt = 0; wr_cnt = 0;
    drive(1, 1, 1, 3'd4, 5'd7, 32'h0000_0100, 0, 32'h80FF_7F01, 0);
    tick("dly0"); tick("dly1"); tick("dly2");
    DMEM_Ack = 1;
    tick("dly_ack");
    chk("dly.stall_cycles", 32'(stall_cnt), 32'd3);
    chk("dly.data_k", MW_WBData, 32'h0000_7F01);
    chk("dly.addr_k", 32'(MW_WBAddr), 32'd7);
    idle(); tick("dly_after");
    chk("dly.one_write", 32'(wr_cnt), 32'd1);

    // Timeout: abandoned after LIM wait cycles, then normal ALU op
    stall_cnt = 0; err_cnt = 0; wr_cnt = 0;
    drive(1, 1, 1, 3'd0, 5'd11, 32'h0000_0040, 0, 32'hAAAA_5555, 0);
    for (int i = 0; i <= LIM; i++) tick("tmo");
    chk("tmo.stall_cycles", 32'(stall_cnt), 32'(LIM + 1));
    idle(); tick("tmo_after");
    chk("tmo.err_once", 32'(err_cnt), 32'd1);
    chk("tmo.no_write", 32'(wr_cnt), 32'd0);
    drive(1, 1, 0, 3'd0, 5'd12, 32'hCAFE_0001, 0, 32'd0, 0);
    tick("tmo_alu"); chk("tmo_alu.wr_k", 32'(MW_RegWrite), 32'd1);

    // r0 guard: address/data move but no write
    drive(1, 1, 0, 3'd0, 5'd0, 32'hDEAD_BEEF, 0, 32'd0, 0);
    tick("r0");
    chk("r0.wr_k", 32'(MW_RegWrite), 32'd0);
    chk("r0.data_k", MW_WBData, 32'hDEAD_BEEF);

    // Flush together with ack in WAIT_MEM
    drive(1, 1, 1, 3'd0, 5'd3, 32'h0000_0000, 0, 32'h1111_2222, 0);
    tick("fl_issue");
    EM_Flush = 1; DMEM_Ack = 1;
    tick("fl_ack");
    chk("fl.wr_k", 32'(MW_RegWrite), 32'd0);
    chk("fl.err_k", 32'(LOAD_Err), 32'd0);
    idle(); tick("fl_after");

    // Async reset while a load is pending
    drive(1, 1, 1, 3'd0, 5'd14, 32'h0000_0000, 0, 32'h3333_4444, 0);
    tick("rw_issue");
    #3;
    rst_n = 0; idle(); model_reset();
    #1;
    chk("mrst.wr",   32'(MW_RegWrite), 32'd0);
    chk("mrst.addr", 32'(MW_WBAddr),   32'd0);
    chk("mrst.data", MW_WBData,        32'd0);
    chk("mrst.err",  32'(LOAD_Err),    32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    DMEM_Ack = 1;
    tick("mrst_after");
    chk("mrst.no_write", 32'(MW_RegWrite), 32'd0);
    idle(); tick("mrst_idle");

    // Random traffic; upstream holds the instruction while stalled
    prev_stall = 0;
    for (int n = 0; n < 400; n++) begin
      if (!prev_stall) begin
        EM_Valid    = ($urandom_range(0, 3) != 0);
        EM_RegWrite = 1'($urandom_range(0, 1));
        EM_MemToReg = 1'($urandom_range(0, 1));
        EM_LoadType = 3'($urandom_range(0, 7));
        EM_WBAddr   = 5'($urandom_range(0, 31));
        EM_ALUOut   = $urandom;
      end
      EM_Flush   = ($urandom_range(0, 15) == 0);
      DMEM_Ack   = ($urandom_range(0, 2) == 0);
      DMEM_RData = $urandom;
      tick("rnd");
      prev_stall = m_stall;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
